// File: rtl/x_cmd_pkg.sv
// Shared types and constants for the x_ctrl command generator: request ops,
// x_ctrl command opcodes, FSM states and the per-op command byte mux.
package x_cmd_pkg;

    typedef enum logic [2:0] {
        OP_WRITE   = 3'd0,
        OP_READ    = 3'd1,
        OP_PLAY    = 3'd2,
        OP_ADVANCE = 3'd3,
        OP_TOP     = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EMIT,
        S_GAP,
        S_WAIT_RSP,
        S_DONE
    } state_e;

    localparam logic [3:0] CMD_ADDR = 4'h0;
    localparam logic [3:0] CMD_DATA = 4'h1;
    localparam logic [3:0] CMD_WR   = 4'h2;
    localparam logic [3:0] CMD_RD   = 4'h3;
    localparam logic [3:0] CMD_PLAY = 4'h4;
    localparam logic [3:0] CMD_ADV  = 4'h5;
    localparam logic [3:0] CMD_TOP  = 4'h6;

    localparam logic [2:0] N_BYTES_WRITE   = 3'd6;
    localparam logic [2:0] N_BYTES_READ    = 3'd4;
    localparam logic [2:0] N_BYTES_PLAY    = 3'd1;
    localparam logic [2:0] N_BYTES_ADVANCE = 3'd4;
    localparam logic [2:0] N_BYTES_TOP     = 3'd3;

    // Wide enough for the largest response timeout (1023 cycles).
    localparam int TMR_W = 10;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

    function automatic logic [2:0] byte_count(input op_e op);
        logic [2:0] n;
        case (op)
            OP_WRITE:   n = N_BYTES_WRITE;
            OP_READ:    n = N_BYTES_READ;
            OP_PLAY:    n = N_BYTES_PLAY;
            OP_ADVANCE: n = N_BYTES_ADVANCE;
            OP_TOP:     n = N_BYTES_TOP;
            default:    n = 3'd1;
        endcase
        return n;
    endfunction

    // Byte idx of the command sequence for op, most significant nibble first.
    function automatic logic [7:0] cmd_byte(input op_e op, input logic [2:0] idx,
                                            input logic [15:0] arg, input logic [5:0] data);
        logic [3:0] addr_nib;
        logic [3:0] rate_nib;
        logic [7:0] b;
        case (idx)
            3'd0:    addr_nib = {1'b0, arg[10:8]};
            3'd1:    addr_nib = arg[7:4];
            default: addr_nib = arg[3:0];
        endcase
        case (idx)
            3'd0:    rate_nib = arg[15:12];
            3'd1:    rate_nib = arg[11:8];
            3'd2:    rate_nib = arg[7:4];
            default: rate_nib = arg[3:0];
        endcase
        case (op)
            OP_WRITE: begin
                case (idx)
                    3'd0, 3'd1, 3'd2: b = {CMD_ADDR, addr_nib};
                    3'd3:             b = {CMD_DATA, 2'b00, data[5:4]};
                    3'd4:             b = {CMD_DATA, data[3:0]};
                    default:          b = {CMD_WR, 4'h0};
                endcase
            end
            OP_READ:    b = (idx < 3'd3) ? {CMD_ADDR, addr_nib} : {CMD_RD, 4'h0};
            OP_PLAY:    b = {CMD_PLAY, 4'h0};
            OP_ADVANCE: b = {CMD_ADV, rate_nib};
            OP_TOP:     b = {CMD_TOP, addr_nib};
            default:    b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/x_cmd_timer.sv
// Loadable down-counter shared by the inter-byte gap and the read-response
// timeout; a load takes priority over counting and the count stops at zero.
module x_cmd_timer
    import x_cmd_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [TMR_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_zero
);

    logic [TMR_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_load_val;
        end else if (i_en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign o_zero = (cnt == '0);

endmodule

// File: rtl/x_cmd_gen.sv
// Serialises one host request at a time into x_ctrl nibble command bytes and,
// for reads, collects the response byte with a timeout.
module x_cmd_gen
    import x_cmd_pkg::*;
#(
    parameter int CMD_GAP     = 0,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [2:0]  i_req_op,
    input  logic [15:0] i_req_arg,
    input  logic [5:0]  i_req_data,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd,
    input  logic        i_rsp_valid,
    input  logic [7:0]  i_rsp,
    output logic        o_done_valid,
    output logic [5:0]  o_done_data,
    output logic        o_done_err
);

    // Timer is loaded with N-1 so the state it guards lasts exactly N cycles.
    localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'((CMD_GAP > 0) ? CMD_GAP - 1 : 0);
    localparam logic [TMR_W-1:0] TO_LOAD  = TMR_W'(RSP_TIMEOUT - 1);

    state_e           state;
    op_e              op_q;
    logic [15:0]      arg_q;
    logic [5:0]       data_q;
    logic [2:0]       idx_q;
    logic [2:0]       idx_nxt;
    logic [7:0]       next_byte;
    logic             last_byte;
    logic             tmr_load;
    logic             tmr_en;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             unused_rsp_hi;

    assign unused_rsp_hi = ^i_rsp[7:6];
    assign idx_nxt       = idx_q + 3'd1;
    assign next_byte     = cmd_byte(op_q, idx_nxt, arg_q, data_q);
    assign last_byte     = (idx_q == byte_count(op_q) - 3'd1);

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = '0;
        case (state)
            S_EMIT: begin
                if (last_byte) begin
                    if (op_q == OP_READ) begin
                        tmr_load = 1'b1;
                        tmr_val  = TO_LOAD;
                    end
                end else if (CMD_GAP > 0) begin
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                end
            end
            S_GAP, S_WAIT_RSP: tmr_en = 1'b1;
            default: ;
        endcase
    end

    x_cmd_timer u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (tmr_load),
        .i_load_val (tmr_val),
        .i_en       (tmr_en),
        .o_zero     (tmr_zero)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            o_req_ready  <= 1'b1;
            o_cmd_valid  <= 1'b0;
            o_cmd        <= 8'h00;
            o_done_valid <= 1'b0;
            o_done_data  <= 6'd0;
            o_done_err   <= 1'b0;
            op_q         <= OP_WRITE;
            arg_q        <= 16'd0;
            data_q       <= 6'd0;
            idx_q        <= 3'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        o_req_ready <= 1'b0;
                        op_q        <= op_e'(i_req_op);
                        arg_q       <= i_req_arg;
                        data_q      <= i_req_data;
                        idx_q       <= 3'd0;
                        if (op_legal(i_req_op)) begin
                            state       <= S_EMIT;
                            o_cmd_valid <= 1'b1;
                            o_cmd       <= cmd_byte(op_e'(i_req_op), 3'd0, i_req_arg, i_req_data);
                        end else begin
                            state        <= S_DONE;
                            o_done_valid <= 1'b1;
                            o_done_data  <= 6'd0;
                            o_done_err   <= 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (last_byte) begin
                        o_cmd_valid <= 1'b0;
                        o_cmd       <= 8'h00;
                        if (op_q == OP_READ) begin
                            state <= S_WAIT_RSP;
                        end else begin
                            state        <= S_DONE;
                            o_done_valid <= 1'b1;
                            o_done_data  <= 6'd0;
                            o_done_err   <= 1'b0;
                        end
                    end else if (CMD_GAP > 0) begin
                        state       <= S_GAP;
                        o_cmd_valid <= 1'b0;
                        o_cmd       <= 8'h00;
                    end else begin
                        o_cmd <= next_byte;
                        idx_q <= idx_nxt;
                    end
                end
                S_GAP: begin
                    if (tmr_zero) begin
                        state       <= S_EMIT;
                        o_cmd_valid <= 1'b1;
                        o_cmd       <= next_byte;
                        idx_q       <= idx_nxt;
                    end
                end
                S_WAIT_RSP: begin
                    // A response on the final wait cycle takes priority over expiry.
                    if (i_rsp_valid) begin
                        state        <= S_DONE;
                        o_done_valid <= 1'b1;
                        o_done_data  <= i_rsp[5:0];
                        o_done_err   <= 1'b0;
                    end else if (tmr_zero) begin
                        state        <= S_DONE;
                        o_done_valid <= 1'b1;
                        o_done_data  <= 6'd0;
                        o_done_err   <= 1'b1;
                    end
                end
                S_DONE: begin
                    state        <= S_IDLE;
                    o_done_valid <= 1'b0;
                    o_done_data  <= 6'd0;
                    o_done_err   <= 1'b0;
                    o_req_ready  <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_x_cmd_gen.sv
// Directed bench for x_cmd_gen: one instance with no gap and an 8-cycle read
// timeout, one with a 2-cycle gap, checked cycle by cycle against hand values.
module tb_x_cmd_gen;

    logic        clk;
    logic        rst;
    logic        req_valid_a;
    logic        req_valid_b;
    logic [2:0]  req_op;
    logic [15:0] req_arg;
    logic [5:0]  req_data;
    logic        rsp_valid;
    logic [7:0]  rsp;

    logic        ready_a, cmd_valid_a, done_valid_a, done_err_a;
    logic [7:0]  cmd_a;
    logic [5:0]  done_data_a;
    logic        ready_b, cmd_valid_b, done_valid_b, done_err_b;
    logic [7:0]  cmd_b;
    logic [5:0]  done_data_b;

    // Output snapshot: {ready, cmd_valid, cmd, done_valid, done_data, done_err}
    logic [17:0] obs_a;
    logic [17:0] obs_b;
    assign obs_a = {ready_a, cmd_valid_a, cmd_a, done_valid_a, done_data_a, done_err_a};
    assign obs_b = {ready_b, cmd_valid_b, cmd_b, done_valid_b, done_data_b, done_err_b};

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] seq[$];

    x_cmd_gen #(.CMD_GAP(0), .RSP_TIMEOUT(8)) dut_a (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid_a),
        .o_req_ready  (ready_a),
        .i_req_op     (req_op),
        .i_req_arg    (req_arg),
        .i_req_data   (req_data),
        .o_cmd_valid  (cmd_valid_a),
        .o_cmd        (cmd_a),
        .i_rsp_valid  (rsp_valid),
        .i_rsp        (rsp),
        .o_done_valid (done_valid_a),
        .o_done_data  (done_data_a),
        .o_done_err   (done_err_a)
    );

    x_cmd_gen #(.CMD_GAP(2), .RSP_TIMEOUT(255)) dut_b (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid_b),
        .o_req_ready  (ready_b),
        .i_req_op     (req_op),
        .i_req_arg    (req_arg),
        .i_req_data   (req_data),
        .o_cmd_valid  (cmd_valid_b),
        .o_cmd        (cmd_b),
        .i_rsp_valid  (rsp_valid),
        .i_rsp        (rsp),
        .o_done_valid (done_valid_b),
        .o_done_data  (done_data_b),
        .o_done_err   (done_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] v_idle();
        return {1'b1, 1'b0, 8'h00, 1'b0, 6'd0, 1'b0};
    endfunction

    function automatic logic [17:0] v_busy();
        return 18'd0;
    endfunction

    function automatic logic [17:0] v_byte(input logic [7:0] b);
        return {1'b0, 1'b1, b, 1'b0, 6'd0, 1'b0};
    endfunction

    function automatic logic [17:0] v_done(input logic [5:0] d, input logic e);
        return {1'b0, 1'b0, 8'h00, 1'b1, d, e};
    endfunction

    task automatic check(input string tag, input logic [17:0] observed, input logic [17:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle, then scramble the fields to prove capture.
    task automatic request(input logic to_b, input logic [2:0] op,
                           input logic [15:0] arg, input logic [5:0] data);
        req_op   = op;
        req_arg  = arg;
        req_data = data;
        if (to_b) req_valid_b = 1'b1;
        else      req_valid_a = 1'b1;
        tick();
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_op      = 3'd7;
        req_arg     = ~arg;
        req_data    = ~data;
    endtask

    // Expect seq back to back on dut_a starting this cycle; ends one cycle past the last byte.
    task automatic check_bytes_a(input string tag);
        for (int i = 0; i < seq.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), obs_a, v_byte(seq[i]));
            tick();
        end
    endtask

    initial begin
        rst         = 1'b1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_op      = 3'd0;
        req_arg     = 16'd0;
        req_data    = 6'd0;
        rsp_valid   = 1'b0;
        rsp         = 8'h00;
        tick();
        tick();
        check("reset_a", obs_a, v_idle());
        check("reset_b", obs_b, v_idle());
        rst = 1'b0;
        tick();
        check("post_reset_a", obs_a, v_idle());

        // WRITE 0x5A3 / 0x2C
        request(1'b0, 3'd0, 16'h05A3, 6'h2C);
        seq = '{8'h05, 8'h0A, 8'h03, 8'h12, 8'h1C, 8'h20};
        check_bytes_a("write");
        check("write_done", obs_a, v_done(6'd0, 1'b0));
        tick();
        check("write_idle", obs_a, v_idle());

        // READ 0x7FF; a response in the 0x30 cycle must be ignored
        request(1'b0, 3'd1, 16'h07FF, 6'h00);
        seq = '{8'h07, 8'h0F, 8'h0F};
        check_bytes_a("read");
        rsp_valid = 1'b1;
        rsp       = 8'h3F;
        check("read_byte3", obs_a, v_byte(8'h30));
        tick();
        rsp_valid = 1'b0;
        check("read_wait1", obs_a, v_busy());
        tick();
        check("read_wait2", obs_a, v_busy());
        tick();
        rsp_valid = 1'b1;
        rsp       = 8'hD5;
        check("read_wait3", obs_a, v_busy());
        tick();
        rsp_valid = 1'b0;
        check("read_done", obs_a, v_done(6'h15, 1'b0));
        tick();
        check("read_idle", obs_a, v_idle());

        // READ with no response: timeout done 9 cycles after 0x30
        request(1'b0, 3'd1, 16'h0123, 6'h00);
        seq = '{8'h01, 8'h02, 8'h03, 8'h30};
        check_bytes_a("rdto");
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("rdto_wait%0d", i), obs_a, v_busy());
            tick();
        end
        check("rdto_done", obs_a, v_done(6'd0, 1'b1));
        tick();
        check("rdto_idle", obs_a, v_idle());

        // READ with response on the final wait cycle: response wins
        request(1'b0, 3'd1, 16'h0400, 6'h00);
        seq = '{8'h04, 8'h00, 8'h00, 8'h30};
        check_bytes_a("rdlast");
        for (int i = 1; i <= 7; i++) begin
            check($sformatf("rdlast_wait%0d", i), obs_a, v_busy());
            tick();
        end
        rsp_valid = 1'b1;
        rsp       = 8'h2A;
        check("rdlast_wait8", obs_a, v_busy());
        tick();
        rsp_valid = 1'b0;
        check("rdlast_done", obs_a, v_done(6'h2A, 1'b0));
        tick();
        check("rdlast_idle", obs_a, v_idle());

        // Illegal op 6, then PLAY, then TOP 0x3C5
        request(1'b0, 3'd6, 16'h1234, 6'h3F);
        check("illegal_done", obs_a, v_done(6'd0, 1'b1));
        tick();
        check("illegal_idle", obs_a, v_idle());
        request(1'b0, 3'd2, 16'hFFFF, 6'h3F);
        seq = '{8'h40};
        check_bytes_a("play");
        check("play_done", obs_a, v_done(6'd0, 1'b0));
        tick();
        check("play_idle", obs_a, v_idle());
        request(1'b0, 3'd4, 16'h03C5, 6'h00);
        seq = '{8'h63, 8'h6C, 8'h65};
        check_bytes_a("top");
        check("top_done", obs_a, v_done(6'd0, 1'b0));
        tick();
        check("top_idle", obs_a, v_idle());

        // ADVANCE 0xBEEF on the gap-2 instance
        request(1'b1, 3'd3, 16'hBEEF, 6'h00);
        seq = '{8'h5B, 8'h5E, 8'h5E, 8'h5F};
        for (int i = 0; i < 4; i++) begin
            check($sformatf("adv_byte%0d", i), obs_b, v_byte(seq[i]));
            tick();
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    check($sformatf("adv_gap%0d_%0d", i, g), obs_b, v_busy());
                    tick();
                end
            end
        end
        check("adv_done", obs_b, v_done(6'd0, 1'b0));
        tick();
        check("adv_idle", obs_b, v_idle());

        // Reset mid-WRITE after two bytes, then a stray response in IDLE
        request(1'b0, 3'd0, 16'h05A3, 6'h2C);
        check("abort_byte0", obs_a, v_byte(8'h05));
        tick();
        check("abort_byte1", obs_a, v_byte(8'h0A));
        rst = 1'b1;
        tick();
        check("abort_in_reset", obs_a, v_idle());
        rst = 1'b0;
        tick();
        check("abort_released", obs_a, v_idle());
        rsp_valid = 1'b1;
        rsp       = 8'h3F;
        tick();
        rsp_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check($sformatf("abort_quiet%0d", i), obs_a, v_idle());
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
